// File: rtl/axi_dac_jesd204_pngen.sv
// Parallel PN9/PN23 generator feeding the JESD204 TX framer; mirrors the ADC-side PN monitor.
// Optional build macro PNGEN_ERR_INJECT_EN enables single-word error injection on dac_data[0].
module axi_dac_jesd204_pngen #(
  parameter int unsigned CHANNEL_WIDTH   = 16,
  parameter int unsigned DATA_PATH_WIDTH = 2,
  parameter bit          TWOS_COMPLEMENT = 1'b1
) (
  input  logic                                       dac_clk,
  input  logic                                       dac_rst,
  input  logic                                       dac_pn_enable,
  input  logic [3:0]                                 dac_pnseq_sel,
  input  logic                                       dac_valid,
  input  logic                                       dac_pn_err_inject,
  output logic [CHANNEL_WIDTH*DATA_PATH_WIDTH-1:0]   dac_data,
  output logic                                       dac_data_valid,
  output logic [31:0]                                dac_pn_word_count
);

  localparam int unsigned W = CHANNEL_WIDTH * DATA_PATH_WIDTH;
  localparam logic [W-1:0] LFSR_SEED = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_s;
  logic [W-1:0]    r_data;
  logic            r_data_valid;
  logic [31:0]     r_count;
  logic [3:0]      r_sel_q;
  logic            w_clear;
  logic            w_seed;
  logic            w_emit;
  logic            w_inj;
  logic [W-1:0]    w_s_next;
  logic [W-1:0]    w_word;

  // Next PN9 word: bits resolved MSB-first from the last 9 bits of the current word.
  function automatic logic [W-1:0] pn9_next(input logic [8:0] tail);
    logic [W+8:0] full;
    full = '0;
    full[W+8:W] = tail;
    for (int k = int'(W) - 1; k >= 0; k--) begin
      full[k] = full[k+9] ^ full[k+5];
    end
    return full[W-1:0];
  endfunction

  // Next PN23 word: bits resolved MSB-first from the last 23 bits of the current word.
  function automatic logic [W-1:0] pn23_next(input logic [22:0] tail);
    logic [W+22:0] full;
    full = '0;
    full[W+22:W] = tail;
    for (int k = int'(W) - 1; k >= 0; k--) begin
      full[k] = full[k+23] ^ full[k+18];
    end
    return full[W-1:0];
  endfunction

  // Reverse sample order so the earliest stream sample lands at the LSBs.
  function automatic logic [W-1:0] swizzle(input logic [W-1:0] s);
    logic [W-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < DATA_PATH_WIDTH; i++) begin
      o[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = s[(DATA_PATH_WIDTH-1-i)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      o[i*CHANNEL_WIDTH + CHANNEL_WIDTH - 1] ^= TWOS_COMPLEMENT;
    end
    return o;
  endfunction

  assign w_s_next = (r_sel_q == 4'd0) ? pn9_next(r_s[8:0]) : pn23_next(r_s[22:0]);
  assign w_word   = swizzle(r_s) ^ {{(W-1){1'b0}}, w_inj};

  // State register.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next state and datapath strobes; disable beats reseed, reseed beats advance.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_seed       = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (dac_pn_enable) w_state_next = SEED;
      end
      SEED: begin
        w_seed       = 1'b1;
        w_state_next = RUN;
      end
      RUN: begin
        if (!dac_pn_enable) begin
          w_state_next = IDLE;
          w_clear      = 1'b1;
        end else if (dac_pnseq_sel != r_sel_q) begin
          w_state_next = SEED;
        end else if (dac_valid) begin
          w_emit = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // LFSR, output word, selection and word counter.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      r_s          <= LFSR_SEED;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_count      <= 32'd0;
      r_sel_q      <= dac_pnseq_sel;
    end else begin
      r_data_valid <= w_emit;
      if (w_clear) r_data <= '0;
      if (w_seed) begin
        r_s     <= LFSR_SEED;
        r_sel_q <= dac_pnseq_sel;
        r_count <= 32'd0;
      end
      if (w_emit) begin
        r_data <= w_word;
        r_s    <= w_s_next;
        if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
      end
    end
  end

`ifdef PNGEN_ERR_INJECT_EN
  logic r_inj_pend;

  // Pulses merge into one pending flip, consumed by the next emitted word.
  assign w_inj = r_inj_pend | dac_pn_err_inject;

  always_ff @(posedge dac_clk) begin
    if (dac_rst)               r_inj_pend <= 1'b0;
    else if (r_state != RUN)   r_inj_pend <= 1'b0;
    else if (w_emit)           r_inj_pend <= 1'b0;
    else                       r_inj_pend <= w_inj;
  end
`else
  logic w_unused_inject;

  assign w_inj           = 1'b0;
  assign w_unused_inject = dac_pn_err_inject;
`endif

  assign dac_data          = r_data;
  assign dac_data_valid    = r_data_valid;
  assign dac_pn_word_count = r_count;

endmodule

// File: tb/tb_axi_dac_jesd204_pngen.sv
// Self-checking bench for axi_dac_jesd204_pngen against a serial bit-stream PN model.
module tb_axi_dac_jesd204_pngen;

  localparam int NW = 256;
  localparam int NB = NW * 32;
`ifdef PNGEN_ERR_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, vld, inj;
  logic [3:0]  sel;
  logic [31:0] data, data0, count, count0;
  logic        dvalid, dvalid0;

  int checks = 0;
  int errors = 0;

  bit          st9  [NB];
  bit          st23 [NB];
  bit          poly;
  int          idx;
  int          cnt;
  logic [31:0] exp_d, exp_d0;

  always #5 clk = ~clk;

  axi_dac_jesd204_pngen #(.CHANNEL_WIDTH(16), .DATA_PATH_WIDTH(2), .TWOS_COMPLEMENT(1'b1)) dut (
    .dac_clk(clk), .dac_rst(rst), .dac_pn_enable(en), .dac_pnseq_sel(sel),
    .dac_valid(vld), .dac_pn_err_inject(inj),
    .dac_data(data), .dac_data_valid(dvalid), .dac_pn_word_count(count)
  );

  axi_dac_jesd204_pngen #(.CHANNEL_WIDTH(16), .DATA_PATH_WIDTH(2), .TWOS_COMPLEMENT(1'b0)) dut_tc0 (
    .dac_clk(clk), .dac_rst(rst), .dac_pn_enable(en), .dac_pnseq_sel(sel),
    .dac_valid(vld), .dac_pn_err_inject(inj),
    .dac_data(data0), .dac_data_valid(dvalid0), .dac_pn_word_count(count0)
  );

  // Word m of the serial stream, first stream bit as MSB.
  function automatic logic [31:0] raw_word(input bit p, input int m);
    logic [31:0] w;
    for (int j = 0; j < 32; j++) w[31-j] = p ? st23[m*32+j] : st9[m*32+j];
    return w;
  endfunction

  // Earliest 16-bit sample goes to the LSBs; optional sample MSB inversion.
  function automatic logic [31:0] exp_out(input logic [31:0] raw, input bit tc);
    return {raw[15:0], raw[31:16]} ^ (tc ? 32'h8000_8000 : 32'h0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle in RUN with the given dac_valid; flip marks an expected injected error.
  task automatic run_one(input bit v, input bit flip);
    vld = v;
    step();
    inj = 1'b0;
    if (v) begin
      exp_d  = exp_out(raw_word(poly, idx), 1'b1) ^ {31'd0, flip};
      exp_d0 = exp_out(raw_word(poly, idx), 1'b0) ^ {31'd0, flip};
      idx++;
      cnt++;
    end
    chk("valid", {31'd0, dvalid}, {31'd0, v});
    chk("data", data, exp_d);
    chk("data_tc0", data0, exp_d0);
    chk("count", count, 32'(cnt));
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) run_one(rnd ? 1'($urandom_range(1, 0)) : 1'b1, 1'b0);
  endtask

  // Two cycles through IDLE/SEED (or RUN->SEED), then restart the model.
  task automatic expect_seed(input bit p);
    step();
    chk("seed_entry_valid", {31'd0, dvalid}, 32'd0);
    step();
    chk("seed_valid", {31'd0, dvalid}, 32'd0);
    chk("seed_count", count, 32'd0);
    poly = p;
    idx  = 0;
    cnt  = 0;
  endtask

  initial begin
    for (int t = 0; t < NB; t++) begin
      st9[t]  = (t < 32) ? 1'b1 : st9[t-9] ^ st9[t-5];
      st23[t] = (t < 32) ? 1'b1 : st23[t-23] ^ st23[t-18];
    end
    rst = 1'b1; en = 1'b0; vld = 1'b0; inj = 1'b0; sel = 4'd0;
    exp_d = 32'd0; exp_d0 = 32'd0;
    step();
    step();
    chk("rst_data", data, 32'd0);
    chk("rst_valid", {31'd0, dvalid}, 32'd0);
    chk("rst_count", count, 32'd0);

    // PN9 start from seed, continuous then gapped dac_valid.
    rst = 1'b0; en = 1'b1; vld = 1'b1;
    expect_seed(1'b0);
    run_one(1'b1, 1'b0);
    chk("first_word", data, 32'h7FFF_7FFF);
    chk("first_word_tc0", data0, 32'hFFFF_FFFF);
    chk("first_count", count, 32'd1);
    run(40, 1'b0);
    run_one(1'b1, 1'b0); run_one(1'b0, 1'b0); run_one(1'b0, 1'b0); run_one(1'b1, 1'b0);
    run(70, 1'b1);

    // Selection change mid-RUN reseeds into PN23.
    sel = 4'd1; vld = 1'b1;
    expect_seed(1'b1);
    run_one(1'b1, 1'b0);
    chk("pn23_first_word", data, 32'h7FFF_7FFF);
    chk("pn23_first_count", count, 32'd1);
    run(60, 1'b1);

    // Error injection right after reseed, then merged pulses during gaps.
    sel = 4'd0; vld = 1'b1;
    expect_seed(1'b0);
    inj = 1'b1;
    run_one(1'b1, INJ);
    chk("inj_first_word", data, INJ ? 32'h7FFF_7FFE : 32'h7FFF_7FFF);
    run(5, 1'b0);
    inj = 1'b1; run_one(1'b0, 1'b0);
    inj = 1'b1; run_one(1'b0, 1'b0);
    run_one(1'b1, INJ);
    run(5, 1'b0);

    // Enable drop together with selection change: IDLE wins and clears data.
    en = 1'b0; sel = 4'd1; vld = 1'b1;
    step();
    chk("disable_data", data, 32'd0);
    chk("disable_valid", {31'd0, dvalid}, 32'd0);
    step();
    chk("idle_data", data, 32'd0);
    chk("idle_valid", {31'd0, dvalid}, 32'd0);
    exp_d = 32'd0; exp_d0 = 32'd0;
    en = 1'b1;
    expect_seed(1'b1);
    run(20, 1'b1);

    // Synchronous reset mid-RUN, then restart from the seed with enable held.
    rst = 1'b1; vld = 1'b1;
    step();
    chk("midrst_data", data, 32'd0);
    chk("midrst_valid", {31'd0, dvalid}, 32'd0);
    chk("midrst_count", count, 32'd0);
    rst = 1'b0;
    exp_d = 32'd0; exp_d0 = 32'd0;
    expect_seed(1'b1);
    run_one(1'b1, 1'b0);
    chk("post_rst_first_word", data, 32'h7FFF_7FFF);
    run(30, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_dac_jesd204_pngen.md
Name: axi_dac_jesd204_pngen

Overview:
- Parallel PN9/PN23 pattern generator for the DAC JESD204 transmit datapath.
- Mirror of the ADC-side PN monitor. Its output, looped through a link into the ADC PN monitor with matching parameters, must lock (oos deasserts) and report no errors.
- Sits between the DAC channel test-pattern mux and the JESD204 TX framer.
- Produces DATA_PATH_WIDTH samples per clock, with sample ordering and sign handling matched to the monitor.

Parameters:
- CHANNEL_WIDTH, 16, bits per sample.
- DATA_PATH_WIDTH, 2, samples per clock.
- TWOS_COMPLEMENT, 1, when 1 the MSB of every output sample is inverted.

Ports:
- dac_clk  in  1  datapath clock.
- dac_rst  in  1  synchronous, active-high reset.
- dac_pn_enable  in  1  level; 1 runs the generator, 0 idles it.
- dac_pnseq_sel  in  4  0 = PN9, any other value = PN23.
- dac_valid  in  1  framer accepts a word this cycle.
- dac_pn_err_inject  in  1  single-cycle pulse; corrupts one output word.
- dac_data  out  CHANNEL_WIDTH*DATA_PATH_WIDTH  generated samples, sample 0 at the LSBs.
- dac_data_valid  out  1  dac_data holds a new word.
- dac_pn_word_count  out  32  count of words emitted since the last restart.

Behaviour:
- Widths and names
  - W = CHANNEL_WIDTH*DATA_PATH_WIDTH; DW = W-1.
  - S: W-bit LFSR word register. Seed = all ones.
- Next-word function f, computed from S
  - PN9: full = {S[8:0], n}; n = full[DW+9:9] ^ full[DW+5:5].
  - PN23: full = {S[22:0], n}; n = full[DW+23:23] ^ full[DW+18:18].
  - n is resolved MSB-first and is purely combinational.
- Swizzle, applied to S to form the output word
  - Sample i of dac_data = S[(DATA_PATH_WIDTH-1-i)*CHANNEL_WIDTH +: CHANNEL_WIDTH].
  - The sample MSB is XORed with TWOS_COMPLEMENT.
- FSM states: IDLE, SEED, RUN.
  - Reset → IDLE.
    - S = seed; dac_data = 0; dac_data_valid = 0; dac_pn_word_count = 0.
    - The selection register sel_q captures dac_pnseq_sel.
  - IDLE
    - dac_data = 0, dac_data_valid = 0.
    - dac_pn_enable = 1 → SEED.
  - SEED, exactly one cycle
    - S ← seed; sel_q ← dac_pnseq_sel; word count ← 0; dac_data_valid = 0.
    - Go to RUN.
  - RUN
    - On dac_valid = 1: dac_data ← swizzle(S); S ← f(S); dac_data_valid ← 1 on the next cycle; count += 1.
    - On dac_valid = 0: S, dac_data and count hold; dac_data_valid ← 0.
  - RUN exits
    - dac_pn_enable = 0 → IDLE next cycle; dac_data cleared to 0.
    - dac_pnseq_sel != sel_q → SEED, regardless of dac_valid. This takes priority over the dac_valid advance.
    - If enable drops and sel changes in the same cycle, IDLE wins.
- Latency: 1 cycle from a dac_valid sample to the corresponding dac_data / dac_data_valid.
- First word after SEED is swizzle(seed): 0x7FFF7FFF with default parameters.
- Word count saturates at 0xFFFFFFFF and does not wrap.
- dac_rst mid-RUN → IDLE next edge; all outputs take their reset values; any in-flight word is dropped.
- The all-zero LFSR state is unreachable, so there is no lockup recovery logic.

Optional Feature:
- Macro: PNGEN_ERR_INJECT_EN.
- When defined:
  - A dac_pn_err_inject pulse sets a pending flag.
  - The next emitted word in RUN with dac_valid = 1 has dac_data[0] inverted. S is not corrupted, so the sequence continues unaffected.
  - The pending flag clears on that emission.
  - Further pulses while the flag is pending are merged into the one injection.
  - SEED, IDLE and reset clear the pending flag.
- When not defined: dac_pn_err_inject is ignored and the pending logic is not synthesised.

Test Plan:
- Reset, then enable=1, sel=0, dac_valid=1 continuously.
  - SEED cycle has dac_data_valid=0.
  - First valid word = 0x7FFF7FFF.
  - Count reads 1 on the cycle after the first word.
- TWOS_COMPLEMENT=0, same stimulus → first word 0xFFFFFFFF.
  - Loop back into the ADC PN monitor, 1000 words each for PN9 and PN23 → monitor oos=0, err never asserted after lock.
- dac_valid toggled 1,0,0,1 → dac_data holds across the 0 cycles; the word sequence is identical to the continuous run with gaps removed.
- sel changed 0→1 mid-RUN → one SEED cycle with valid=0, next word 0x7FFF7FFF, count restarts at 1.
  - The monitor re-locks on PN23.
- With PNGEN_ERR_INJECT_EN, inject pulse immediately after SEED → first word 0x7FFF7FFE.
  - Monitor sees exactly one err pulse and stays in sync.
  - Without the macro, the word is 0x7FFF7FFF.
- dac_rst asserted mid-RUN → next edge: dac_data=0, valid=0, count=0, state IDLE.
  - After reset with enable held high, the sequence restarts from the seed.
